// File: rtl/deadlock_mon_pkg.sv
// Shared types and defaults for the kernel deadlock monitor.
package deadlock_mon_pkg;

  localparam int DEFAULT_STALL_THRESHOLD = 16;
  localparam int DEFAULT_CNT_W           = 16;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } dm_state_e;

endpackage

// File: rtl/deadlock_stall_counter.sv
// Saturating stall counter with synchronous clear and enable.
// match flags that the next increment would land exactly on THRESH,
// letting the controller declare deadlock on the same edge the count gets there.
module deadlock_stall_counter #(
  parameter int W      = 16,
  parameter int THRESH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         match
);

  localparam logic [W-1:0] THRESH_V = W'(THRESH);

  logic [W-1:0] count_inc;

  // Increment that sticks at all-ones instead of wrapping to 0.
  always_comb begin
    count_inc = (count == '1) ? count : count + W'(1);
    match     = (count_inc == THRESH_V);
  end

  // Counter register: clear wins over enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/axis_deadlock_detector.sv
// Per-kernel deadlock detector. A kernel is considered deadlocked when every
// non-top instance is either idle or blocked on its stream channel, something
// is actually blocked, and the blocking pattern has not changed for
// STALL_THRESHOLD consecutive cycles. Once declared, the flag is sticky.
//
// The state output is a debug view of the FSM (MONITOR/SUSPECT/BLOCKED).
// There is no valid/ready handshake on this block: all inputs are level
// signals sampled every rising clock edge.
module axis_deadlock_detector
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS          = 2,
  parameter int N_INST          = 3,
  parameter int N_BLK           = 1,
  parameter int STALL_THRESHOLD = DEFAULT_STALL_THRESHOLD,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_BLK-1:0]  inst_block_sigs,
  output logic              block,
  output logic              block_pending,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [N_AXIS-1:0] block_snapshot,
  output dm_state_e         state
);

  localparam int PAT_W = N_AXIS + N_BLK;

  dm_state_e        next_state;
  logic             stall_cond;
  logic             all_waiting;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] sig_reg;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_match;
  logic             snap_load;

  // Stall condition: something is blocked and every child instance is idle
  // or stuck on its own channel. An all-idle kernel is quiescent, not stalled.
  always_comb begin
    all_waiting = 1'b1;
    for (int i = 1; i < N_INST; i++) begin
      all_waiting = all_waiting & (inst_idle_sigs[i] | axis_block_sigs[i-1]);
    end
    stall_cond = ((|axis_block_sigs) | (|inst_block_sigs)) & all_waiting;
    pattern    = {axis_block_sigs, inst_block_sigs};
  end

  deadlock_stall_counter #(
    .W      (CNT_W),
    .THRESH (STALL_THRESHOLD)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (stall_cycles),
    .match  (cnt_match)
  );

  // Next-state and counter control. A drop or pattern change in SUSPECT
  // takes priority over reaching the threshold on the same cycle.
  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    snap_load  = 1'b0;
    case (state)
      MONITOR: begin
        if (stall_cond) begin
          cnt_en = 1'b1;
          if (cnt_match) begin
            next_state = BLOCKED;
            snap_load  = 1'b1;
          end else begin
            next_state = SUSPECT;
          end
        end else begin
          cnt_clear = 1'b1;
        end
      end
      SUSPECT: begin
        if (!stall_cond || (pattern != sig_reg)) begin
          next_state = MONITOR;
          cnt_clear  = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cnt_match) begin
            next_state = BLOCKED;
            snap_load  = 1'b1;
          end
        end
      end
      BLOCKED: begin
        cnt_en = stall_cond;
      end
      default: begin
        next_state = MONITOR;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // State, previous-pattern and snapshot registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= MONITOR;
      sig_reg        <= '0;
      block_snapshot <= '0;
    end else begin
      state   <= next_state;
      sig_reg <= pattern;
      if (snap_load) begin
        block_snapshot <= axis_block_sigs;
      end
    end
  end

  assign block         = (state == BLOCKED);
  assign block_pending = (state == SUSPECT);

endmodule

// File: tb/tb_axis_deadlock_detector.sv
// Directed bench for axis_deadlock_detector: a vector table for short
// sequences plus hand-written loops for threshold, saturation and reset cases.
module tb_axis_deadlock_detector;
  import deadlock_mon_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  axis_block_sigs;
  logic [2:0]  inst_idle_sigs;
  logic [0:0]  inst_block_sigs;
  logic        block;
  logic        block_pending;
  logic [15:0] stall_cycles;
  logic [1:0]  block_snapshot;
  dm_state_e   state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  axis;
    logic [2:0]  idle;
    logic        blk;
    logic        e_block;
    logic        e_pend;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  axis_deadlock_detector dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block),
    .block_pending   (block_pending),
    .stall_cycles    (stall_cycles),
    .block_snapshot  (block_snapshot),
    .state           (state)
  );

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic [1:0] a, input logic [2:0] i, input logic b);
    axis_block_sigs    = a;
    inst_idle_sigs     = i;
    inst_block_sigs[0] = b;
    @(posedge clock);
    #1;
  endtask

  // Reset pulse for one edge while holding the given inputs.
  task automatic do_reset(input logic [1:0] a, input logic [2:0] i, input logic b);
    reset = 1'b1;
    step(a, i, b);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic e_block, input logic e_pend,
                       input logic [15:0] e_cnt);
    checks++;
    if ({block, block_pending, stall_cycles} !== {e_block, e_pend, e_cnt}) begin
      errors++;
      $display("FAIL %s: block=%b pend=%b cnt=%0d, expected block=%b pend=%b cnt=%0d",
               name, block, block_pending, stall_cycles, e_block, e_pend, e_cnt);
    end
  endtask

  task automatic check_snap(input string name, input logic [1:0] e_snap);
    checks++;
    if (block_snapshot !== e_snap) begin
      errors++;
      $display("FAIL %s: snapshot=%b expected=%b", name, block_snapshot, e_snap);
    end
  endtask

  task automatic add_vec(input logic [1:0] a, input logic [2:0] i, input logic b,
                         input logic eb, input logic ep, input logic [15:0] ec);
    vec_t v;
    v.axis = a; v.idle = i; v.blk = b; v.e_block = eb; v.e_pend = ep; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  initial begin
    // Vector table: expected outputs are sampled after each vector's edge.
    // Steady stall for 15 cycles, dropped on the 16th: no deadlock.
    for (int k = 1; k <= 15; k++) add_vec(2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 16'(k));
    add_vec(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0);
    add_vec(2'b00, 3'b111, 1'b0, 1'b0, 1'b0, 16'd0);
    // Inter-process block with children idle counts as a stall.
    add_vec(2'b00, 3'b110, 1'b1, 1'b0, 1'b1, 16'd1);
    add_vec(2'b00, 3'b110, 1'b1, 1'b0, 1'b1, 16'd2);
    add_vec(2'b00, 3'b110, 1'b1, 1'b0, 1'b1, 16'd3);
    // Pattern change while still stalled: back to MONITOR, then restart at 1.
    add_vec(2'b01, 3'b110, 1'b1, 1'b0, 1'b0, 16'd0);
    add_vec(2'b01, 3'b110, 1'b1, 1'b0, 1'b1, 16'd1);
    add_vec(2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 16'd0);
    add_vec(2'b01, 3'b110, 1'b0, 1'b0, 1'b1, 16'd1);
    add_vec(2'b00, 3'b111, 1'b0, 1'b0, 1'b0, 16'd0);

    reset              = 1'b1;
    axis_block_sigs    = '0;
    inst_idle_sigs     = '0;
    inst_block_sigs    = '0;
    do_reset(2'b00, 3'b000, 1'b0);
    check("reset_state", 1'b0, 1'b0, 16'd0);
    check_snap("reset_snap", 2'b00);

    // Quiescent kernel: never a deadlock.
    for (int k = 0; k < 100; k++) begin
      step(2'b00, 3'b000, 1'b0);
      check("idle", 1'b0, 1'b0, 16'd0);
    end

    // Partial stall: instance 2 neither idle nor blocked.
    for (int k = 0; k < 50; k++) begin
      step(2'b01, 3'b000, 1'b0);
      check("partial_stall", 1'b0, 1'b0, 16'd0);
    end

    // Table-driven section.
    do_reset(2'b00, 3'b111, 1'b0);
    foreach (tbl[n]) begin
      step(tbl[n].axis, tbl[n].idle, tbl[n].blk);
      check($sformatf("vec%0d", n), tbl[n].e_block, tbl[n].e_pend, tbl[n].e_cnt);
    end

    // Progress reset: pattern change restarts the count.
    do_reset(2'b00, 3'b111, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(2'b01, 3'b100, 1'b0);
      check("prog_first", 1'b0, 1'b1, 16'(k));
    end
    step(2'b10, 3'b010, 1'b0);
    check("prog_change", 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 15; k++) begin
      step(2'b10, 3'b010, 1'b0);
      check("prog_second", 1'b0, 1'b1, 16'(k));
    end
    step(2'b10, 3'b010, 1'b0);
    check("prog_block", 1'b1, 1'b0, 16'd16);
    check_snap("prog_snap", 2'b10);

    // Steady deadlock, frozen snapshot, hold on drop, saturation.
    do_reset(2'b00, 3'b111, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step(2'b11, 3'b000, 1'b0);
      check("steady_pend", 1'b0, 1'b1, 16'(k));
    end
    step(2'b11, 3'b000, 1'b0);
    check("steady_block", 1'b1, 1'b0, 16'd16);
    check_snap("steady_snap", 2'b11);
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 3'b000, 1'b0);
      check("blocked_hold", 1'b1, 1'b0, 16'd16);
    end
    check_snap("snap_frozen", 2'b11);
    for (int k = 1; k <= 65519; k++) begin
      step(2'b11, 3'b000, 1'b0);
      if (k == 100) check("blocked_count", 1'b1, 1'b0, 16'd116);
    end
    check("sat_reach", 1'b1, 1'b0, 16'hFFFF);
    for (int k = 0; k < 5; k++) step(2'b11, 3'b000, 1'b0);
    check("sat_hold", 1'b1, 1'b0, 16'hFFFF);

    // Reset in BLOCKED with the stall still held.
    do_reset(2'b11, 3'b000, 1'b0);
    check("rst_blocked", 1'b0, 1'b0, 16'd0);
    check_snap("rst_snap", 2'b00);
    for (int k = 1; k <= 15; k++) begin
      step(2'b11, 3'b000, 1'b0);
      check("rerun_pend", 1'b0, 1'b1, 16'(k));
    end
    step(2'b11, 3'b000, 1'b0);
    check("rerun_block", 1'b1, 1'b0, 16'd16);

    // Reset mid-SUSPECT.
    do_reset(2'b11, 3'b000, 1'b0);
    for (int k = 0; k < 5; k++) step(2'b11, 3'b000, 1'b0);
    check("mid_suspect", 1'b0, 1'b1, 16'd5);
    do_reset(2'b11, 3'b000, 1'b0);
    check("rst_suspect", 1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
